// File: rtl/left_shift_register_base.sv
// Serial-in / parallel-out left shift register: shifts left on enabled edges, loading
// the serial input into bit 0 and discarding the MSB. Synchronous active-high clear.
module left_shift_register_base #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             in,
    input  logic             clk,
    input  logic             enable,
    input  logic             reset,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    // Reset takes priority so an unknown enable cannot leak into the cleared state.
    always_comb begin
        shift_d = shift_q;
        if (enable) begin
            shift_d = {shift_q[WIDTH-2:0], in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign out = shift_q;

endmodule

// File: tb/tb_left_shift_register_base.sv
// Self-checking bench for left_shift_register_base: directed and random steps, with
// expected values queued at drive time and popped after each rising edge.
module tb_left_shift_register_base;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] out;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    logic [W-1:0] model;

    always #5 clk = ~clk;

    left_shift_register_base #(.WIDTH(W)) dut (
        .in     (in),
        .clk    (clk),
        .enable (enable),
        .reset  (reset),
        .out    (out)
    );

    task automatic compare(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic pop_check();
        logic [W-1:0] expv;
        string        tag;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
        end else begin
            expv = exp_q.pop_front();
            tag = tag_q.pop_front();
            compare(tag, out, expv);
        end
    endtask

    // Drive one edge's inputs away from the edge, queue the expectation, check 1 unit after.
    task automatic step(input logic r, input logic e, input logic d,
                        input logic [W-1:0] expv, input string tag);
        @(negedge clk);
        reset = r;
        enable = e;
        in = d;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        logic r;
        logic e;
        logic d;

        // Reset with enable high: reset must win.
        step(1'b1, 1'b1, 1'b1, 8'b00000000, "reset");

        // Basic shift 1,0,1,0.
        step(1'b0, 1'b1, 1'b1, 8'b00000001, "shift0");
        step(1'b0, 1'b1, 1'b0, 8'b00000010, "shift1");
        step(1'b0, 1'b1, 1'b1, 8'b00000101, "shift2");
        step(1'b0, 1'b1, 1'b0, 8'b00001010, "shift3");

        // No combinational path from in to out mid-cycle.
        @(negedge clk);
        in = 1'b1;
        #2;
        compare("no_comb_path", out, 8'b00001010);

        // Sync reset mid-stream, then release with in=1 and no dead cycle.
        step(1'b1, 1'b1, 1'b1, 8'b00000000, "mid_reset");
        step(1'b0, 1'b1, 1'b1, 8'b00000001, "release_shift");

        // Pattern 1,1,0,1,0,1,1 after reset.
        step(1'b1, 1'b0, 1'b0, 8'b00000000, "pat_reset");
        step(1'b0, 1'b1, 1'b1, 8'b00000001, "pat0");
        step(1'b0, 1'b1, 1'b1, 8'b00000011, "pat1");
        step(1'b0, 1'b1, 1'b0, 8'b00000110, "pat2");
        step(1'b0, 1'b1, 1'b1, 8'b00001101, "pat3");
        step(1'b0, 1'b1, 1'b0, 8'b00011010, "pat4");
        step(1'b0, 1'b1, 1'b1, 8'b00110101, "pat5");
        step(1'b0, 1'b1, 1'b1, 8'b01101011, "pat6");

        // Overflow: MSB discarded.
        step(1'b0, 1'b1, 1'b0, 8'b11010110, "ovf0");
        step(1'b0, 1'b1, 1'b0, 8'b10101100, "ovf1");

        // Enable low holds a non-zero value.
        step(1'b0, 1'b0, 1'b1, 8'b10101100, "hold_nz0");
        step(1'b0, 1'b0, 1'b0, 8'b10101100, "hold_nz1");

        // Enable low from zero with in=1 stays zero.
        step(1'b1, 1'b0, 1'b0, 8'b00000000, "en_low_reset");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'b00000000, "en_low_hold");
        end

        // Reset clears with enable low, and with enable unknown.
        step(1'b0, 1'b1, 1'b1, 8'b00000001, "load_one");
        step(1'b1, 1'b0, 1'b1, 8'b00000000, "reset_en_low");
        step(1'b0, 1'b1, 1'b1, 8'b00000001, "load_one_b");
        step(1'b1, 1'bx, 1'b1, 8'b00000000, "reset_en_x");

        // Random steps against a reference model.
        model = '0;
        for (int i = 0; i < 60; i++) begin
            r = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 1));
            if (r) begin
                model = '0;
            end else if (e) begin
                model = {model[W-2:0], d};
            end
            step(r, e, d, model, "random");
        end

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
